// File: rtl/ex_muldiv_pkg.sv
// Shared EX-stage definitions: mult/div op encodings, muldiv FSM states,
// counter sizing and two's-complement helpers.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;
  // Helpers work on a wide container; callers zero-extend in and truncate out.
  localparam int MAX_W = 128;

  function automatic int f_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic logic [MAX_W-1:0] f_neg(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] f_cond_neg(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? f_neg(v) : v;
  endfunction

  function automatic logic [MAX_W-1:0] f_abs(input logic [MAX_W-1:0] v, input logic is_signed,
                                             input int w);
    return f_cond_neg(v, is_signed & v[w-1]);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One radix-2 step per cycle on magnitudes, sign fix-up in a final cycle.
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int OPBITS = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [OPBITS-1:0] i_op,
  input  logic [NBITS-1:0]  i_OperandoA,
  input  logic [NBITS-1:0]  i_OperandoB,
  input  logic              i_WriteHI,
  input  logic              i_WriteLO,
  output logic [NBITS-1:0]  o_HI,
  output logic [NBITS-1:0]  o_LO,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_DivZero
);

  localparam int CW = f_cnt_w(NBITS);

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*NBITS-1:0] r_acc;
  logic [NBITS-1:0]   r_b, r_hi, r_lo;
  logic               r_is_div, r_sgn_q, r_sgn_r, r_dz, r_done, r_divz;

  op_e                w_op;
  logic               w_signed, w_is_div, w_sa, w_sb;
  logic [NBITS-1:0]   w_abs_a, w_abs_b;
  logic [NBITS:0]     w_mul_sum, w_rem_sh, w_diff;
  logic               w_qbit;
  logic [NBITS-1:0]   w_rem_nxt;
  logic [2*NBITS-1:0] w_acc_mul, w_acc_div, w_prod;
  logic [NBITS-1:0]   w_quo, w_rem;

  assign w_op     = op_e'(i_op[1:0]);
  assign w_signed = (w_op == OP_MULT) || (w_op == OP_DIV);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_sa     = w_signed & i_OperandoA[NBITS-1];
  assign w_sb     = w_signed & i_OperandoB[NBITS-1];
  assign w_abs_a  = NBITS'(f_abs(MAX_W'(i_OperandoA), w_signed, NBITS));
  assign w_abs_b  = NBITS'(f_abs(MAX_W'(i_OperandoB), w_signed, NBITS));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_acc[2*NBITS-1:NBITS]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_acc_mul = {w_mul_sum, r_acc[NBITS-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  // A zero divisor naturally yields quotient all-ones and remainder = dividend.
  assign w_rem_sh  = {r_acc[2*NBITS-1:NBITS], r_acc[NBITS-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nxt = w_qbit ? w_diff[NBITS-1:0] : w_rem_sh[NBITS-1:0];
  assign w_acc_div = {w_rem_nxt, r_acc[NBITS-2:0], w_qbit};

  assign w_prod = (2*NBITS)'(f_cond_neg(MAX_W'(r_acc), r_sgn_q));
  assign w_quo  = r_dz ? '1 : NBITS'(f_cond_neg(MAX_W'(r_acc[NBITS-1:0]), r_sgn_q));
  // Signed divide-by-zero: corrected |A| restores the original dividend in HI.
  assign w_rem  = NBITS'(f_cond_neg(MAX_W'(r_acc[2*NBITS-1:NBITS]), r_sgn_r));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == CW'(1)) w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_sgn_q  <= 1'b0;
      r_sgn_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_divz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      r_divz  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_WriteHI) r_hi <= i_OperandoA;
          if (i_WriteLO) r_lo <= i_OperandoA;
          if (i_start) begin
            r_acc    <= {{NBITS{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            r_b      <= w_is_div ? w_abs_b : w_abs_a;
            r_is_div <= w_is_div;
            r_sgn_q  <= w_sa ^ w_sb;
            r_sgn_r  <= w_sa;
            r_dz     <= w_is_div && (i_OperandoB == '0);
            r_cnt    <= CW'(NBITS);
          end
        end
        ST_CALC: begin
          r_acc <= r_is_div ? w_acc_div : w_acc_mul;
          r_cnt <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*NBITS-1:NBITS];
            r_lo <= w_prod[NBITS-1:0];
          end
          r_done <= 1'b1;
          r_divz <= r_dz;
        end
        default: ;
      endcase
    end
  end

  assign o_HI      = r_hi;
  assign o_LO      = r_lo;
  assign o_Busy    = (r_state != ST_IDLE);
  assign o_Done    = r_done;
  assign o_DivZero = r_divz;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed test-plan cases plus
// randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_OperandoA = '0;
  logic [31:0] i_OperandoB = '0;
  logic        i_WriteHI = 1'b0;
  logic        i_WriteLO = 1'b0;
  logic [31:0] o_HI, o_LO;
  logic        o_Busy, o_Done, o_DivZero;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  ex_muldiv_unit #(.NBITS(32), .OPBITS(2)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
    .i_OperandoA(i_OperandoA), .i_OperandoB(i_OperandoB),
    .i_WriteHI(i_WriteHI), .i_WriteLO(i_WriteLO),
    .o_HI(o_HI), .o_LO(o_LO), .o_Busy(o_Busy), .o_Done(o_Done), .o_DivZero(o_DivZero)
  );

  always #5 i_clk = ~i_clk;

  // Reference: plain integer arithmetic on the architectural definitions.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb;
    dz = 1'b0;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00: begin ps = longint'(sa) * longint'(sb); pu = 64'(ps); hi = pu[63:32]; lo = pu[31:0]; end
      2'b01: begin pu = {32'b0, a} * {32'b0, b}; hi = pu[63:32]; lo = pu[31:0]; end
      default: begin
        if (b == 0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          hi = 32'h0; lo = 32'h8000_0000;
        end else if (op == 2'b10) begin
          lo = 32'(sa / sb); hi = 32'(sa % sb);
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endtask

  // Launch from the current negedge and follow the op to its o_Done cycle.
  // mid_evt: 0 none, 1 MTLO during CALC, 2 new i_start during CALC.
  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mid_evt);
    logic [31:0] mh, ml;
    logic        mdz;
    int          nb;
    bit          got;
    model(op, a, b, mh, ml, mdz);
    i_op = op; i_OperandoA = a; i_OperandoB = b; i_start = 1'b1;
    nb = 0; got = 0;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (o_Done) begin got = 1; break; end
      if (o_Busy) nb++;
      if (mid_evt == 1 && c == 10) begin i_WriteLO = 1'b1; i_OperandoA = ~a; end
      else if (mid_evt == 2 && c == 10) begin i_start = 1'b1; i_op = ~op; i_OperandoA = ~a; end
      else begin i_WriteLO = 1'b0; i_start = 1'b0; end
      if (c == 12) begin
        vectors++;
        if (o_LO !== exp_lo) begin errors++; $display("FAIL %s lo_during_calc: got %h want %h", name, o_LO, exp_lo); end
      end
      @(negedge i_clk);
    end
    i_WriteLO = 1'b0; i_start = 1'b0;
    vectors++;
    if (!got) begin errors++; $display("FAIL %s done_timeout: no o_Done within 100 cycles", name); end
    vectors++;
    if (nb != 33) begin errors++; $display("FAIL %s busy_cycles: got %0d want 33", name, nb); end
    vectors++;
    if (o_Busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, o_Busy); end
    vectors++;
    if (o_HI !== mh) begin errors++; $display("FAIL %s hi: got %h want %h (a=%h b=%h op=%0d)", name, o_HI, mh, a, b, op); end
    vectors++;
    if (o_LO !== ml) begin errors++; $display("FAIL %s lo: got %h want %h (a=%h b=%h op=%0d)", name, o_LO, ml, a, b, op); end
    vectors++;
    if (o_DivZero !== mdz) begin errors++; $display("FAIL %s divzero: got %b want %b", name, o_DivZero, mdz); end
    exp_hi = mh; exp_lo = ml;
  endtask

  task automatic test_reset;
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_HI, o_LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h_%h want 0", o_HI, o_LO); end
    vectors++;
    if ({o_Busy, o_Done, o_DivZero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {o_Busy, o_Done, o_DivZero}); end
    i_reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed;
    @(negedge i_clk); check_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    vectors++;
    if ({o_HI, o_LO} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", o_HI, o_LO); end
    @(negedge i_clk); check_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0);
    vectors++;
    if ({o_HI, o_LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_neg3x7_const: got %h_%h want ffffffff_ffffffeb", o_HI, o_LO); end
    @(negedge i_clk); check_op("mult_zero", 2'b00, 32'h0, 32'h8000_0000, 0);
    @(negedge i_clk); check_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    vectors++;
    if ({o_HI, o_LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_m7_2_const: got %h_%h want ffffffff_fffffffd", o_HI, o_LO); end
  endtask

  task automatic test_back_to_back;
    // Launched in the o_Done cycle of the previous DIV.
    check_op("b2b_divu_7_2", 2'b11, 32'd7, 32'd2, 0);
    vectors++;
    if ({o_HI, o_LO} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL b2b_const: got %h_%h want 1_3", o_HI, o_LO); end
  endtask

  task automatic test_div_corner;
    @(negedge i_clk); check_op("divu_by0", 2'b11, 32'h1234_5678, 32'h0, 0);
    @(negedge i_clk); check_op("div_s_by0", 2'b10, 32'hFFFF_FF00, 32'h0, 0);
    @(negedge i_clk); check_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
  endtask

  task automatic test_mthi_mtlo;
    @(negedge i_clk);
    i_WriteHI = 1'b1; i_OperandoA = 32'hAAAA_0000;
    @(negedge i_clk);
    i_WriteHI = 1'b0; exp_hi = 32'hAAAA_0000;
    vectors++;
    if (o_HI !== exp_hi || o_LO !== exp_lo) begin errors++; $display("FAIL mthi: got %h_%h want %h_%h", o_HI, o_LO, exp_hi, exp_lo); end
    i_WriteLO = 1'b1; i_OperandoA = 32'h0000_5555;
    @(negedge i_clk);
    i_WriteLO = 1'b0; exp_lo = 32'h0000_5555;
    vectors++;
    if (o_LO !== exp_lo || o_HI !== exp_hi) begin errors++; $display("FAIL mtlo: got %h_%h want %h_%h", o_HI, o_LO, exp_hi, exp_lo); end
    check_op("mtlo_mid_calc", 2'b01, 32'h0001_0003, 32'h0000_0101, 1);
    @(negedge i_clk); check_op("start_mid_calc", 2'b00, 32'h7FFF_FFFF, 32'h8000_0001, 2);
    @(negedge i_clk);
    vectors++;
    if (o_Done !== 1'b0 || o_Busy !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b busy=%b want 0 0", o_Done, o_Busy); end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    i_op = 2'b00; i_OperandoA = 32'h0123_4567; i_OperandoB = 32'hFEDC_BA98; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (9) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    vectors++;
    if (o_Busy !== 1'b0 || o_HI !== 32'h0 || o_LO !== 32'h0) begin errors++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0", o_Busy, o_HI, o_LO); end
    for (int c = 0; c < 40; c++) begin
      if (o_Done || o_Busy) seen = 1;
      @(negedge i_clk);
    end
    vectors++;
    if (seen) begin errors++; $display("FAIL reset_mid_trace: got activity after reset want none"); end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [1:0]  op;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = 32'($urandom_range(1, 17));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if (n % 3 == 0) @(negedge i_clk);
      check_op("random", op, a, b, 0);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_div_corner;
    test_mthi_mtlo;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the MIPS pipeline. It consumes the forwarded register operands: operand A from the rs forwarding path and operand B from the ALU source/forwarding mux output. It executes MULT/MULTU/DIV/DIVU over NBITS+1 cycles and holds the result in architectural HI/LO registers. While it is running it raises a busy flag, which the hazard unit uses to stall any following MFHI/MFLO/MTHI/MTLO/mult/div.

## Interface
Parameters:
- NBITS, 32, operand and HI/LO width
- OPBITS, 2, operation select width

Ports:
- i_clk  in  1  single clock, all state updates on rising edge
- i_reset  in  1  synchronous reset, active-low
- i_start  in  1  launch the operation in i_op; sampled only in IDLE
- i_op  in  OPBITS  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- i_OperandoA  in  NBITS  rs value (multiplicand / dividend)
- i_OperandoB  in  NBITS  rt value after forwarding mux (multiplier / divisor)
- i_WriteHI  in  1  MTHI: HI <= i_OperandoA
- i_WriteLO  in  1  MTLO: LO <= i_OperandoA
- o_HI  out  NBITS  HI register
- o_LO  out  NBITS  LO register
- o_Busy  out  1  operation in progress
- o_Done  out  1  one-cycle pulse; HI/LO hold the new result
- o_DivZero  out  1  pulses with o_Done when a DIV/DIVU had divisor 0

## Operation
- States: IDLE, CALC, FIX.
- IDLE with i_start=1:
  - Latch the operands. For signed ops, latch their absolute values.
  - Record the result signs:
    - product/quotient sign = signA ^ signB
    - remainder sign = signA
    - unsigned ops: no sign correction
  - Load counter = NBITS, go to CALC.
- CALC performs one radix-2 step per cycle:
  - Multiply: shift-add into a 2·NBITS accumulator.
  - Divide: restoring shift-subtract, producing a quotient bit and a partial remainder.
  - Decrement the counter. When the counter reaches 0, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Multiply: {HI,LO} <= signed product.
  - Divide: LO <= quotient, HI <= remainder (truncation toward zero).
  - Pulse o_Done, go to IDLE.
- Divisor 0 (DIV or DIVU): HI <= i_OperandoA as latched, LO <= all ones, no sign correction, o_DivZero=1.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural wrap; no trap is raised.
- i_WriteHI / i_WriteLO:
  - Honoured only in IDLE; ignored in CALC/FIX, where the hazard unit guarantees a stall.
  - If asserted in the same IDLE cycle as i_start, the write still happens. The later FIX result overwrites it.
- i_start while o_Busy=1: ignored, no effect on the current op.
- i_op is latched at start; later changes have no effect.

## Timing
- Reset (i_reset=0 at any edge, including mid-CALC/FIX) forces the following:
  - state IDLE, counter 0
  - o_HI=0, o_LO=0
  - o_Busy=0, o_Done=0, o_DivZero=0
  - The aborted operation leaves no trace.
- i_start sampled at edge E0 (in IDLE) runs as follows:
  - CALC covers E1..E32.
  - FIX is written at E33.
  - o_Busy=1 from after E0 until after E33, i.e. 33 cycles.
  - o_Busy is the combinational decode of state != IDLE.
  - o_Done/o_DivZero are registered and high exactly in the cycle after E33.
  - o_HI/o_LO show the new values from that same cycle.
- Back-to-back: a new i_start is accepted in the o_Done cycle.
- The MTHI/MTLO write is visible the cycle after its edge.
- o_HI/o_LO are driven directly from registers, so MFHI/MFLO reads have zero added latency.

## Structure
- Shared pipeline package holds:
  - the op encodings MULT/MULTU/DIV/DIVU (also used by the control unit)
  - the state encoding IDLE/CALC/FIX
  - a counter width constant $clog2(NBITS)+1
- Single module; no sub-module required.
- Absolute-value and negate helpers live as functions in the package.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 busy cycles, o_Done=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also MULT 0 × 0x80000000 -> HI=LO=0.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then, started in the o_Done cycle, DIVU 7 / 2 -> LO=3, HI=1.
- DIVU 0x12345678 / 0 -> HI=0x12345678, LO=0xFFFFFFFF, o_DivZero=1 with o_Done. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, o_DivZero=0.
- MTHI 0xAAAA0000 in IDLE -> o_HI=0xAAAA0000 next cycle. i_WriteLO asserted mid-CALC -> LO unchanged. i_start mid-CALC -> ignored, o_Done only once.
- i_reset=0 at E10 of a MULT -> next cycle o_Busy=0, HI=LO=0, no o_Done pulse afterwards.
